axi_rd_xbar: RTL and testbench
==============================

AXI_RD_XBAR -- requirements
Module: axi_rd_xbar

Interface
REQ-001 The block SHALL have parameter CLINT_BASE, default 32'hA000_0048, base address of the CLINT slave window.
REQ-002 The block SHALL have parameter CLINT_MASK, default 32'hFFFF_FFF8, address compare mask for the CLINT window.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  asynchronous reset, active low
REQ-004 The block SHALL have these upstream read-master ports:
- arid_i  in  4  read ID
- araddr_i  in  32  read address
- arlen_i  in  8  burst length minus 1
- arsize_i  in  3  beat size
- arburst_i  in  2  burst type
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rid_o  out  4  R ID
- rdata_o  out  32  R data
- rresp_o  out  2  R response
- rlast_o  out  1  R last beat
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready
REQ-005 The block SHALL have these downstream slave ports, where index 0 is the default slave, index 1 is CLINT, and the AR payload is broadcast to both:
- s_arid_o  out  4  registered ID
- s_araddr_o  out  32  registered address
- s_arlen_o  out  8  registered length
- s_arsize_o  out  3  registered size
- s_arburst_o  out  2  registered burst
- s_arvalid_o  out  2  per-slave AR valid
- s_arready_i  in  2  per-slave AR ready
- s_rdata_i  in  64  {slave1, slave0} R data
- s_rresp_i  in  4  {slave1, slave0} R response
- s_rlast_i  in  2  per-slave R last
- s_rvalid_i  in  2  per-slave R valid
- s_rready_o  out  2  per-slave R ready

Function
REQ-006 The block SHALL use the FSM states IDLE, ADDR, DATA and ERR; ERR exists only with XBAR_DECERR_EN.
REQ-007 The block SHALL assert arready_o if and only if the state is IDLE.
REQ-008 On arvalid_i&arready_o, the block SHALL register ID, addr, len, size and burst, and register sel=((araddr_i&CLINT_MASK)==CLINT_BASE).
REQ-009 On that handshake the block SHALL go IDLE->ADDR, so s_arvalid_o[sel] rises exactly 1 cycle after the handshake.
REQ-010 In ADDR the block SHALL hold s_arvalid_o[sel]=1 and the payload stable until s_arready_i[sel]=1, then go ADDR->DATA.
REQ-011 The block SHALL keep s_arvalid_o[~sel]=0 at all times.
REQ-012 In DATA the block SHALL pass R through combinationally: rvalid_o=s_rvalid_i[sel], rdata/rresp/rlast from slave sel, and s_rready_o[sel]=rready_i.
REQ-013 The block SHALL keep s_rready_o[~sel]=0 and drive rid_o from the registered ID.
REQ-014 In DATA the block SHALL go DATA->IDLE on the beat where rvalid_o&rready_i&rlast_o; earlier beats keep it in DATA.
REQ-015 Outside DATA/ERR the block SHALL hold rvalid_o=0, rlast_o=0, rdata_o=0 and rresp_o=0.
REQ-016 The block SHALL allow at most one outstanding transaction and SHALL NOT accept a new AR before the final R beat completes.
REQ-017 Minimum turnaround SHALL be 1 idle cycle: arready_o rises the cycle after the last beat.
REQ-018 The block SHALL NOT alter R data and SHALL propagate SLVERR/DECERR from slaves unchanged.

Reset
REQ-019 While rst_n_i=0 the block SHALL asynchronously force state=IDLE, sel=0, registered payload=0, s_arvalid_o=0, s_rready_o=0 and rvalid_o=0.
REQ-020 With arready_o=1 during reset, reset asserted mid-ADDR/DATA SHALL abandon the transaction with no beat emitted after reset.
REQ-021 Release SHALL be synchronous-safe: the first handshake is accepted no earlier than the first rising edge after deassertion.

Configuration
REQ-022 With XBAR_DECERR_EN defined, an address with araddr_i[31:28]==4'hA that misses the CLINT window SHALL go IDLE->ERR with no slave AR issued.
REQ-023 In ERR the block SHALL return arlen+1 beats with rdata_o=0, rresp_o=2'b11 and rlast_o on the final beat, then return to IDLE.
REQ-024 With XBAR_DECERR_EN undefined, such addresses SHALL route to slave 0 and state ERR SHALL be absent.

Verification
REQ-025 Bench SHALL cover: AR 0xA000_0048, slave1 arready after 3 cycles -> s_arvalid_o=2'b10 held 3 cycles, payload stable, 1 R beat forwarded.
REQ-026 Bench SHALL cover: AR 0x8000_0000, arlen=3, rready toggling -> 4 beats forwarded in order, return to IDLE only on rlast, s_rready_o[1]=0 throughout.
REQ-027 Bench SHALL cover: arvalid_i held through DATA -> arready_o=0 until the cycle after the last beat, second AR accepted then.
REQ-028 Bench SHALL cover: AR 0xA000_0100, XBAR_DECERR_EN defined -> no s_arvalid_o, 1 beat rresp 2'b11, rdata 0; undefined -> routed to slave 0.
REQ-029 Bench SHALL cover: rst_n_i low mid-DATA on beat 2 of 4 -> all valids 0 immediately, IDLE with arready_o=1 after release.

Source files
------------

// File: rtl/axi_rd_xbar.sv
// axi_rd_xbar: single-outstanding AXI read crossbar, one master to {default slave 0, CLINT slave 1}
// Ports: clk_i/rst_n_i (async active-low); upstream AR/R master channel (ar*_i, arready_o, r*_o, rready_i);
// downstream registered AR payload broadcast to both slaves (s_ar*_o), per-slave s_arvalid_o/s_arready_i,
// packed {slave1, slave0} R inputs and per-slave s_rready_o.
// Optional: define XBAR_DECERR_EN to answer unmapped 0xA??????? reads locally with DECERR beats.
module axi_rd_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'hA000_0048,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_FFF8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [3:0]  s_arid_o,
  output logic [31:0] s_araddr_o,
  output logic [7:0]  s_arlen_o,
  output logic [2:0]  s_arsize_o,
  output logic [1:0]  s_arburst_o,
  output logic [1:0]  s_arvalid_o,
  input  logic [1:0]  s_arready_i,
  input  logic [63:0] s_rdata_i,
  input  logic [3:0]  s_rresp_i,
  input  logic [1:0]  s_rlast_i,
  input  logic [1:0]  s_rvalid_i,
  output logic [1:0]  s_rready_o
);
`ifdef XBAR_DECERR_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif
  state_t state, state_nx;
  logic sel, hit;
  assign hit = (araddr_i & CLINT_MASK) == CLINT_BASE;
  assign arready_o = state == IDLE;
  assign rid_o = s_arid_o;
`ifdef XBAR_DECERR_EN
  logic [7:0] cnt;
  logic dec_err;
  assign dec_err = araddr_i[31:28] == 4'hA && !hit;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (arvalid_i && arready_o) cnt <= '0;
    else if (state == ERR && rready_i) cnt <= cnt + 8'd1;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      sel         <= 1'b0;
      s_arid_o    <= '0;
      s_araddr_o  <= '0;
      s_arlen_o   <= '0;
      s_arsize_o  <= '0;
      s_arburst_o <= '0;
    end else begin
      state <= state_nx;
      if (arvalid_i && arready_o) begin
        sel         <= hit;
        s_arid_o    <= arid_i;
        s_araddr_o  <= araddr_i;
        s_arlen_o   <= arlen_i;
        s_arsize_o  <= arsize_i;
        s_arburst_o <= arburst_i;
      end
    end
  end
  always_comb begin
    state_nx    = state;
    s_arvalid_o = 2'b00;
    s_rready_o  = 2'b00;
    rvalid_o    = 1'b0;
    rdata_o     = '0;
    rresp_o     = 2'b00;
    rlast_o     = 1'b0;
    case (state)
      IDLE:
`ifdef XBAR_DECERR_EN
        if (arvalid_i) state_nx = dec_err ? ERR : ADDR;
`else
        if (arvalid_i) state_nx = ADDR;
`endif
      ADDR: begin
        s_arvalid_o[sel] = 1'b1;
        if (s_arready_i[sel]) state_nx = DATA;
      end
      DATA: begin
        rvalid_o        = s_rvalid_i[sel];
        rdata_o         = sel ? s_rdata_i[63:32] : s_rdata_i[31:0];
        rresp_o         = sel ? s_rresp_i[3:2] : s_rresp_i[1:0];
        rlast_o         = s_rlast_i[sel];
        s_rready_o[sel] = rready_i;
        if (rvalid_o && rready_i && rlast_o) state_nx = IDLE;
      end
`ifdef XBAR_DECERR_EN
      ERR: begin
        rvalid_o = 1'b1;
        rresp_o  = 2'b11;
        rlast_o  = cnt == s_arlen_o;
        if (rready_i && rlast_o) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_rd_xbar.sv
// tb_axi_rd_xbar: randomized self-checking bench for axi_rd_xbar against a transaction-level model
module tb_axi_rd_xbar;
  localparam logic [31:0] BASE = 32'hA000_0048;
  localparam logic [31:0] MASK = 32'hFFFF_FFF8;
`ifdef XBAR_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [7:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i, arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o, rvalid_o, rready_i;
  logic [3:0]  s_arid_o;
  logic [31:0] s_araddr_o;
  logic [7:0]  s_arlen_o;
  logic [2:0]  s_arsize_o;
  logic [1:0]  s_arburst_o, s_arvalid_o, s_arready_i;
  logic [63:0] s_rdata_i;
  logic [3:0]  s_rresp_i;
  logic [1:0]  s_rlast_i, s_rvalid_i, s_rready_o;
  logic [3:0]  cur_id;
  logic [31:0] cur_addr;
  logic [7:0]  cur_len;
  logic [2:0]  cur_size;
  logic [1:0]  cur_burst;
  int n_chk = 0, n_pass = 0;
  axi_rd_xbar dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
    .s_arsize_o(s_arsize_o), .s_arburst_o(s_arburst_o), .s_arvalid_o(s_arvalid_o),
    .s_arready_i(s_arready_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i),
    .s_rlast_i(s_rlast_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic quiet();
    arvalid_i = 1'b0; s_arready_i = '0; s_rvalid_i = '0; s_rlast_i = '0;
    s_rdata_i = '0; s_rresp_i = '0; rready_i = 1'b0;
  endtask
  // One read transaction. pre: AR was already accepted at the end of the previous call.
  // hold: keep arvalid_i high through the transaction. rst_beat: pull reset when that many beats are done.
  task automatic txn(input logic [31:0] a, input int len, input int ardly, input int rr_mode,
                     input bit hold, input bit pre, input int rst_beat);
    bit s, e, vld;
    int si, b, k;
    logic [31:0] d[$];
    logic [1:0] rs[$];
    if (!pre) begin
      cur_id = 4'($urandom); cur_addr = a; cur_len = 8'(len);
      cur_size = 3'($urandom); cur_burst = 2'($urandom);
      arid_i = cur_id; araddr_i = a; arlen_i = cur_len; arsize_i = cur_size;
      arburst_i = cur_burst; arvalid_i = 1'b1;
      @(negedge clk_i);
      check("arready_idle", 64'(arready_o), 64'd1);
      check("rvalid_idle", 64'(rvalid_o), 64'd0);
      cyc();
    end
    arvalid_i = hold;
    s = (cur_addr & MASK) == BASE;
    e = DEC && cur_addr[31:28] == 4'hA && !s;
    si = int'(s);
    for (int i = 0; i <= len; i++) begin
      d.push_back($urandom);
      rs.push_back(2'($urandom));
    end
    if (!e)
      for (k = 0; k <= ardly; k++) begin
        s_arready_i = 2'($urandom);
        s_arready_i[si] = k == ardly;
        @(negedge clk_i);
        check("s_arvalid", 64'(s_arvalid_o), s ? 64'd2 : 64'd1);
        check("s_ar_payload", {s_arid_o, s_araddr_o, s_arlen_o, s_arsize_o, s_arburst_o},
              {cur_id, cur_addr, cur_len, cur_size, cur_burst});
        check("arready_addr", 64'(arready_o), 64'd0);
        check("rvalid_addr", 64'(rvalid_o), 64'd0);
        cyc();
      end
    s_arready_i = '0;
    b = 0;
    for (k = 0; k < 200 && b <= len; k++) begin
      if (b == rst_beat) begin
        s_rvalid_i = 2'b11; rready_i = 1'b1; rst_n_i = 1'b0;
        #1;
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_s_arvalid", 64'(s_arvalid_o), 64'd0);
        check("rst_s_rready", 64'(s_rready_o), 64'd0);
        check("rst_arready", 64'(arready_o), 64'd1);
        check("rst_payload", 64'(s_araddr_o), 64'd0);
        cyc();
        quiet();
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_arready", 64'(arready_o), 64'd1);
        check("post_rst_rvalid", 64'(rvalid_o), 64'd0);
        cyc();
        return;
      end
      vld = e ? 1'b1 : $urandom_range(0, 3) != 0;
      rready_i = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? k[0] : 1'($urandom);
      s_rvalid_i = 2'($urandom);
      s_rdata_i = {$urandom, $urandom};
      s_rresp_i = 4'($urandom);
      s_rlast_i = 2'($urandom);
      if (!e) begin
        s_rvalid_i[si] = vld;
        s_rdata_i[si*32 +: 32] = d[b];
        s_rresp_i[si*2 +: 2] = rs[b];
        s_rlast_i[si] = b == len;
      end
      @(negedge clk_i);
      check("rvalid", 64'(rvalid_o), 64'(vld));
      if (vld) begin
        check("rdata", 64'(rdata_o), e ? 64'd0 : 64'(d[b]));
        check("rresp", 64'(rresp_o), e ? 64'd3 : 64'(rs[b]));
        check("rlast", 64'(rlast_o), 64'(b == len));
        check("rid", 64'(rid_o), 64'(cur_id));
      end
      check("s_rready", 64'(s_rready_o), (e || !rready_i) ? 64'd0 : s ? 64'd2 : 64'd1);
      check("s_arvalid_data", 64'(s_arvalid_o), 64'd0);
      check("arready_data", 64'(arready_o), 64'd0);
      if (vld && rready_i) b++;
      cyc();
    end
    check("beats", 64'(b), 64'(len + 1));
    quiet();
    arvalid_i = hold;
    @(negedge clk_i);
    check("turnaround_arready", 64'(arready_o), 64'd1);
    check("idle_rvalid", 64'(rvalid_o), 64'd0);
    check("idle_rdata", {rdata_o, rresp_o, rlast_o}, 64'd0);
    check("idle_s_arvalid", 64'(s_arvalid_o), 64'd0);
    cyc();
  endtask
  initial begin
    logic [31:0] a;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0;
    quiet();
    @(negedge clk_i);
    check("reset_arready", 64'(arready_o), 64'd1);
    check("reset_valids", {s_arvalid_o, s_rready_o, rvalid_o}, 64'd0);
    check("reset_payload", {s_arid_o, s_araddr_o, s_arlen_o, s_arsize_o, s_arburst_o}, 64'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    txn(32'hA000_0048, 0, 2, 0, 1'b0, 1'b0, -1);
    txn(32'h8000_0000, 3, 0, 1, 1'b0, 1'b0, -1);
    txn(32'h8000_0040, 1, 1, 2, 1'b1, 1'b0, -1);
    txn(32'h8000_0040, 1, 1, 2, 1'b0, 1'b1, -1);
    txn(32'hA000_0100, 0, 0, 0, 1'b0, 1'b0, -1);
    txn(32'h8000_0000, 3, 0, 0, 1'b0, 1'b0, 2);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: a = BASE | 32'($urandom_range(0, 7));
        1: a = 32'hA000_0000 | ($urandom & 32'h0FFF_FFFC);
        2: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
        default: a = $urandom;
      endcase
      txn(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0,
          $urandom_range(0, 9) == 0 ? 1 : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
